bist_sequencer: RTL and testbench
=================================

// Module: bist_sequencer
// PURPOSE
//  Self-test controller for the gray/sobel core. Seeds the LFSR, runs a fixed number of pseudo-random
//  pixels through the core, waits for the signature analyzer, compares signature to a golden value and
//  reports pass/fail/timeout. Replaces manual pin sequencing of the seed, LFSR-enable and SA-enable controls.
// PARAMETERS
//  SIG_W      8      width of seed, golden value and signature (matches MAX_PIXEL_BITS)
//  CNT_W      16     width of pixel counter and num_px_i
//  TIMEOUT_W  20     width of watchdog counter
//  TIMEOUT    20'hFFFFF  cycles allowed in RUN+DRAIN before abort with timeout
// PORTS
//  clk             in   1      clock
//  nreset_i        in   1      reset, asynchronous, active-low
//  start_i         in   1      start pulse, sampled in IDLE/DONE only
//  abort_i         in   1      synchronous abort, any state
//  seed_i          in   SIG_W  LFSR seed, latched on accepted start
//  golden_i        in   SIG_W  expected signature, latched on accepted start
//  num_px_i        in   CNT_W  pixels to generate, latched on accepted start
//  lfsr_seed_o     out  SIG_W  seed to LFSR config_data_i
//  lfsr_seed_vld_o out  1      one-cycle config strobe to LFSR config_rdy_i
//  lfsr_en_o       out  1      LFSR run enable (level)
//  lfsr_px_rdy_i   in   1      LFSR emitted a pixel this cycle
//  sa_en_o         out  1      signature analyzer enable (level)
//  sa_done_i       in   1      signature analyzer finished
//  sa_signature_i  in   SIG_W  signature value, valid when sa_done_i=1
//  busy_o          out  1      high in SEED/RUN/DRAIN/CHECK
//  done_o          out  1      high in DONE
//  pass_o          out  1      signature matched; valid while done_o=1
//  timeout_o       out  1      watchdog expired; valid while done_o=1
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0; latched seed/golden/num_px 0.
//  - States: IDLE, SEED, RUN, DRAIN, CHECK, DONE (registered Moore outputs, except lfsr_seed_o=latched seed).
//  - IDLE/DONE: start_i=1 -> latch inputs, clear pass/timeout/counters, go SEED next cycle.
//    num_px_i==0 on start -> go directly DONE with pass_o=0, timeout_o=0 (no LFSR/SA activity).
//  - SEED: lfsr_seed_vld_o=1 for exactly one cycle -> RUN.
//  - RUN: lfsr_en_o=1, sa_en_o=1; pixel counter += lfsr_px_rdy_i; when counter reaches num_px
//    (increment that makes count==num_px) -> DRAIN; lfsr_en_o drops the first DRAIN cycle.
//  - DRAIN: lfsr_en_o=0, sa_en_o=1; on sa_done_i=1 capture sa_signature_i -> CHECK.
//  - CHECK: one cycle; pass = (captured signature == golden) -> DONE.
//  - DONE: done_o=1, pass_o/timeout_o held; sa_en_o=0; stays until start_i or abort_i.
//  - Watchdog: counts every cycle in RUN and DRAIN, clears on leaving them; reaching TIMEOUT
//    -> DONE with timeout_o=1, pass_o=0, enables dropped.
//  - Priorities, same cycle: abort_i > sa_done_i/last-pixel > timeout; start_i while busy ignored.
//  - abort_i: any state -> IDLE next cycle, all outputs 0, counters cleared; abort+start -> IDLE.
//  - Pixel counter saturates at num_px; extra lfsr_px_rdy_i in DRAIN ignored.
//  - sa_done_i outside DRAIN ignored. Async reset mid-run returns to reset values immediately.
// STRUCTURE
//  - Package bist_pkg: typedef enum logic [2:0] bist_state_t {IDLE,SEED,RUN,DRAIN,CHECK,DONE};
//    localparams SIG_W/CNT_W defaults shared with LFSR and signature analyzer.
//  - One sub-module: bist_watchdog (clear, enable, TIMEOUT compare, expired pulse).
//  - FSM, pixel counter, capture/compare registers in this module.
// TESTING
//  1 Nominal: seed=8'hA5, num_px=16, golden=model signature -> one seed strobe, 16 rdy counted,
//    lfsr_en_o low after 16th, sa_done -> done_o=1, pass_o=1, timeout_o=0.
//  2 Mismatch: same run, golden=8'h00 vs signature 8'h3C -> done_o=1, pass_o=0, timeout_o=0.
//  3 Timeout: TIMEOUT=64, num_px=4, never assert sa_done_i -> done_o=1 at 64 cycles in RUN+DRAIN,
//    timeout_o=1, pass_o=0, sa_en_o=0.
//  4 Abort: abort_i at pixel 5 of 16 -> IDLE next cycle, all outputs 0; abort+start same cycle -> IDLE.
//  5 Edge: num_px=0 -> DONE with pass_o=0, no seed strobe; start_i during RUN ignored;
//    sa_done_i and watchdog expiry same cycle -> pass/fail result, timeout_o=0.
//  6 Restart from DONE with new seed 8'h5A -> flags cleared on accept, second run completes;
//    async reset mid-RUN -> all outputs 0 at once.

Source files
------------

// File: rtl/bist_sequencer_pkg.sv
// Shared types and default widths for the BIST sequencer and its neighbours.
// The LFSR and signature analyzer use the same SIG_W/CNT_W defaults.
package bist_pkg;

    localparam int DEF_SIG_W     = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_TIMEOUT_W = 20;
    localparam logic [DEF_TIMEOUT_W-1:0] DEF_TIMEOUT = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        RUN,
        DRAIN,
        CHECK,
        DONE
    } bist_state_t;

endpackage

// File: rtl/bist_sequencer_if.sv
// Control bundle between the BIST sequencer (master) and the LFSR /
// signature analyzer pair (slave).
interface bist_sequencer_if #(
    parameter int SIG_W = 8
);

    logic [SIG_W-1:0] lfsr_seed_o;
    logic             lfsr_seed_vld_o;
    logic             lfsr_en_o;
    logic             lfsr_px_rdy_i;
    logic             sa_en_o;
    logic             sa_done_i;
    logic [SIG_W-1:0] sa_signature_i;

    modport master (
        output lfsr_seed_o,
        output lfsr_seed_vld_o,
        output lfsr_en_o,
        output sa_en_o,
        input  lfsr_px_rdy_i,
        input  sa_done_i,
        input  sa_signature_i
    );

    modport slave (
        input  lfsr_seed_o,
        input  lfsr_seed_vld_o,
        input  lfsr_en_o,
        input  sa_en_o,
        output lfsr_px_rdy_i,
        output sa_done_i,
        output sa_signature_i
    );

endinterface

// File: rtl/bist_sequencer_watchdog.sv
// Cycle watchdog: counts while enabled, clears when idle, flags expiry
// on the TIMEOUT-th enabled cycle and every enabled cycle after it.
module bist_watchdog #(
    parameter int                   TIMEOUT_W = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
) (
    input  logic clk,
    input  logic nreset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT - 1'b1;

    logic [TIMEOUT_W-1:0] cnt_q;

    // Saturating so expiry persists if a higher-priority event masked it.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q <= '0;
        end else if (clear_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/bist_sequencer.sv
// Self-test controller: seeds the LFSR, counts pixels, waits for the
// signature analyzer and reports pass / fail / timeout.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int SIG_W     = DEF_SIG_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             nreset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [SIG_W-1:0] seed_i,
    input  logic [SIG_W-1:0] golden_i,
    input  logic [CNT_W-1:0] num_px_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    bist_sequencer_if.master bus
);

    bist_state_t      state_q, state_n;
    logic [CNT_W-1:0] px_cnt_q, px_cnt_n, px_inc;
    logic [CNT_W-1:0] num_px_q;
    logic [SIG_W-1:0] seed_q, golden_q, sig_q;
    logic             pass_q, pass_n;
    logic             tmo_q, tmo_n;
    logic             latch, capture, px_hit;
    logic             seed_vld_q, lfsr_en_q, sa_en_q;
    logic             busy_q, done_q;
    logic             wd_en, wd_expired;

    assign px_inc = px_cnt_q + 1'b1;
    assign px_hit = bus.lfsr_px_rdy_i
                 && (px_cnt_q != num_px_q);
    assign wd_en  = (state_q == RUN)
                 || (state_q == DRAIN);

    bist_watchdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .clear_i   (abort_i),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_n  = state_q;
        px_cnt_n = px_cnt_q;
        pass_n   = pass_q;
        tmo_n    = tmo_q;
        latch    = 1'b0;
        capture  = 1'b0;
        if (abort_i) begin
            state_n  = IDLE;
            px_cnt_n = '0;
            pass_n   = 1'b0;
            tmo_n    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        latch    = 1'b1;
                        px_cnt_n = '0;
                        pass_n   = 1'b0;
                        tmo_n    = 1'b0;
                        state_n  = (num_px_i == '0) ? DONE : SEED;
                    end
                end
                SEED: state_n = RUN;
                RUN: begin
                    if (px_hit) px_cnt_n = px_inc;
                    // Last pixel outranks the watchdog in the same cycle.
                    if (px_hit && px_inc == num_px_q) begin
                        state_n = DRAIN;
                    end else if (wd_expired) begin
                        state_n = DONE;
                        tmo_n   = 1'b1;
                        pass_n  = 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.sa_done_i) begin
                        capture = 1'b1;
                        state_n = CHECK;
                    end else if (wd_expired) begin
                        state_n = DONE;
                        tmo_n   = 1'b1;
                        pass_n  = 1'b0;
                    end
                end
                CHECK: begin
                    pass_n  = (sig_q == golden_q);
                    state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= IDLE;
            px_cnt_q   <= '0;
            num_px_q   <= '0;
            seed_q     <= '0;
            golden_q   <= '0;
            sig_q      <= '0;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
            seed_vld_q <= 1'b0;
            lfsr_en_q  <= 1'b0;
            sa_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            px_cnt_q <= px_cnt_n;
            pass_q   <= pass_n;
            tmo_q    <= tmo_n;
            if (latch) begin
                seed_q   <= seed_i;
                golden_q <= golden_i;
                num_px_q <= num_px_i;
            end
            if (capture) sig_q <= bus.sa_signature_i;
            // Outputs are decoded from the next state so they align with it.
            seed_vld_q <= (state_n == SEED);
            lfsr_en_q  <= (state_n == RUN);
            sa_en_q    <= (state_n == RUN) || (state_n == DRAIN);
            busy_q     <= (state_n == SEED) || (state_n == RUN)
                       || (state_n == DRAIN) || (state_n == CHECK);
            done_q     <= (state_n == DONE);
        end
    end

    assign bus.lfsr_seed_o     = seed_q;
    assign bus.lfsr_seed_vld_o = seed_vld_q;
    assign bus.lfsr_en_o       = lfsr_en_q;
    assign bus.sa_en_o         = sa_en_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign pass_o              = pass_q;
    assign timeout_o           = tmo_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Randomized scoreboard bench for bist_sequencer with a cycle-schedule
// reference model; results are checked whenever done_o rises.
module tb_bist_sequencer;

    localparam int T = 64;
    localparam int L = 70;

    typedef struct {
        bit         pass;
        bit         tmo;
        int         seeds;
        int         en_cyc;
        int         sa_cyc;
        logic [7:0] seed;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  seed_i = '0;
    logic [7:0]  golden_i = '0;
    logic [15:0] num_px_i = '0;
    logic        busy_o, done_o, pass_o, timeout_o;

    bist_sequencer_if #(.SIG_W(8)) bus ();

    bist_sequencer #(
        .SIG_W     (8),
        .CNT_W     (16),
        .TIMEOUT_W (20),
        .TIMEOUT   (20'd64)
    ) dut (
        .clk       (clk),
        .nreset_i  (nreset_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .seed_i    (seed_i),
        .golden_i  (golden_i),
        .num_px_i  (num_px_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .pass_o    (pass_o),
        .timeout_o (timeout_o),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    bit   rdy_s[L];
    bit   dn_s[L];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.lfsr_seed_vld_o, bus.lfsr_en_o, bus.sa_en_o,
                     busy_o, done_o, pass_o, timeout_o});
    endfunction

    // Reference: walk the per-cycle schedule from the first RUN cycle.
    function automatic exp_t model(input int n, input logic [7:0] seed,
                                   input logic [7:0] sig,
                                   input logic [7:0] gold);
        exp_t e;
        int   cnt = 0;
        bit   drain = 0;
        e = '{pass: 0, tmo: 0, seeds: 0, en_cyc: 0, sa_cyc: 0, seed: seed};
        if (n == 0) return e;
        e.seeds = 1;
        for (int k = 0; k < L; k++) begin
            if (!drain) begin
                if (rdy_s[k]) cnt++;
                if (cnt == n) begin
                    drain = 1;
                    e.en_cyc = k + 1;
                end else if (k >= T - 1) begin
                    e.tmo = 1;
                    e.en_cyc = k + 1;
                    e.sa_cyc = k + 1;
                    return e;
                end
            end else if (dn_s[k]) begin
                e.pass = (sig == gold);
                e.sa_cyc = k + 1;
                return e;
            end else if (k >= T - 1) begin
                e.tmo = 1;
                e.sa_cyc = k + 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic clr_sched();
        for (int k = 0; k < L; k++) begin
            rdy_s[k] = 0;
            dn_s[k]  = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.lfsr_px_rdy_i = 0;
        bus.sa_done_i = 0;
        abort_i = 0;
        start_i = 0;
    endtask

    task automatic run(input int n, input logic [7:0] seed,
                       input logic [7:0] gold, input logic [7:0] sig,
                       input int abort_k, input bit start_in_run);
        if (abort_k < 0) exp_q.push_back(model(n, seed, sig, gold));
        @(posedge clk); #1;
        start_i = 1;
        seed_i = seed;
        golden_i = gold;
        num_px_i = n[15:0];
        @(posedge clk); #1;
        start_i = 0;
        seed_i = 8'($urandom);
        golden_i = 8'($urandom);
        num_px_i = 16'($urandom);
        @(posedge clk);
        for (int k = 0; k < L; k++) begin
            #1;
            bus.lfsr_px_rdy_i = rdy_s[k];
            bus.sa_done_i = dn_s[k];
            bus.sa_signature_i = dn_s[k] ? sig : 8'($urandom);
            abort_i = (k == abort_k);
            start_i = start_in_run && (k == 0);
            @(posedge clk);
            if (k == abort_k) begin
                #1 idle_inputs();
                @(negedge clk);
                chk("abort_outs", outs(), 0);
                break;
            end
        end
        #1 idle_inputs();
    endtask

    // Monitor: per-run activity counts, compared when done_o rises.
    initial begin
        int         seeds = 0, en_c = 0, sa_c = 0;
        logic [7:0] seen = '0;
        bit         dprev = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!nreset_i) begin
                seeds = 0; en_c = 0; sa_c = 0; dprev = 0;
            end else begin
                if (start_i && !busy_o) begin
                    seeds = 0; en_c = 0; sa_c = 0;
                end else begin
                    if (bus.lfsr_seed_vld_o) begin
                        seeds++;
                        seen = bus.lfsr_seed_o;
                    end
                    en_c += int'(bus.lfsr_en_o);
                    sa_c += int'(bus.sa_en_o);
                end
                if (done_o && !dprev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pass", int'(pass_o), int'(e.pass));
                        chk("timeout", int'(timeout_o), int'(e.tmo));
                        chk("seed_strobes", seeds, e.seeds);
                        chk("lfsr_en_cycles", en_c, e.en_cyc);
                        chk("sa_en_cycles", sa_c, e.sa_cyc);
                        chk("done_enables",
                            int'({bus.lfsr_en_o, bus.sa_en_o, busy_o}), 0);
                        if (e.seeds > 0) chk("seed_value", int'(seen),
                                             int'(e.seed));
                    end
                end
                dprev = done_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bus.sa_signature_i = '0;
        idle_inputs();
        clr_sched();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", outs(), 0);
        chk("reset_seed", int'(bus.lfsr_seed_o), 0);
        nreset_i = 1;
        @(negedge clk);
        chk("post_reset_outs", outs(), 0);

        // Nominal pass, then mismatch against golden 00.
        for (int k = 0; k < 16; k++) rdy_s[k] = 1;
        dn_s[20] = 1;
        run(16, 8'hA5, 8'h3C, 8'h3C, -1, 0);
        run(16, 8'hA5, 8'h00, 8'h3C, -1, 0);

        // Timeout: no sa_done ever.
        clr_sched();
        for (int k = 0; k < 4; k++) rdy_s[k] = 1;
        run(4, 8'h11, 8'h22, 8'h22, -1, 0);

        // abort + start in the same cycle from DONE.
        @(posedge clk); #1;
        start_i = 1; abort_i = 1; num_px_i = 16'd5;
        @(posedge clk); #1;
        start_i = 0; abort_i = 0;
        @(negedge clk);
        chk("abort_start_outs", outs(), 0);

        // Abort at pixel 5 of 16.
        clr_sched();
        for (int k = 0; k < 16; k++) rdy_s[k] = 1;
        run(16, 8'h33, 8'h44, 8'h44, 4, 0);

        // num_px = 0 from IDLE.
        run(0, 8'h66, 8'h66, 8'h66, -1, 0);

        // start during RUN ignored.
        clr_sched();
        for (int k = 0; k < 16; k++) rdy_s[k] = 1;
        dn_s[18] = 1;
        run(16, 8'h5A, 8'h77, 8'h77, -1, 1);

        // sa_done on the watchdog-expiry cycle.
        clr_sched();
        for (int k = 0; k < 4; k++) rdy_s[k] = 1;
        dn_s[T-1] = 1;
        run(4, 8'h5A, 8'h81, 8'h81, -1, 0);

        // Last pixel on the expiry cycle, then sa_done.
        clr_sched();
        for (int k = T - 4; k < T; k++) rdy_s[k] = 1;
        dn_s[T] = 1;
        run(4, 8'h5A, 8'h90, 8'h91, -1, 0);

        // Randomized runs, restarting from DONE.
        for (int r = 0; r < 25; r++) begin
            int         n;
            logic [7:0] sig, gold;
            n = int'($urandom_range(1, 20));
            for (int k = 0; k < L; k++) begin
                rdy_s[k] = ($urandom_range(0, 3) != 0);
                dn_s[k]  = ($urandom_range(0, 7) == 0);
            end
            sig  = 8'($urandom);
            gold = $urandom_range(0, 1) ? sig : 8'($urandom);
            run(n, 8'($urandom), gold, sig, -1,
                1'($urandom_range(0, 1)));
        end

        // Async reset mid-RUN.
        @(posedge clk); #1;
        start_i = 1; num_px_i = 16'd16; seed_i = 8'h77;
        bus.lfsr_px_rdy_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_run", int'(bus.lfsr_en_o), 1);
        #1 nreset_i = 0;
        #1;
        chk("async_reset_outs", outs(), 0);
        chk("async_reset_seed", int'(bus.lfsr_seed_o), 0);
        @(posedge clk); #1;
        nreset_i = 1;
        bus.lfsr_px_rdy_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
